// File: rtl/bpsk_phase_sequencer_if.sv
// ---------------------------------------------------------------------------
// bpsk_phase_sequencer_if
// Bit-input handshake and sample-output bus of the BPSK phase sequencer.
//   bit_valid    : source -> sequencer, bit_data is held and valid
//   bit_data     : source -> sequencer, data bit (0 = 0 deg, 1 = 180 deg)
//   bit_ready    : sequencer -> source, bit is taken this cycle if valid
//   phase        : sequencer -> sine table, table index
//   phase_valid  : sequencer -> sine table, phase is a live sample
//   symbol_start : sequencer -> sink, first sample of a symbol
// master = bit source / sample sink side, slave = sequencer side.
// ---------------------------------------------------------------------------
interface bpsk_phase_sequencer_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  bit_valid;
   logic                  bit_data;
   logic                  bit_ready;
   logic [DATA_WIDTH-1:0] phase;
   logic                  phase_valid;
   logic                  symbol_start;

   modport master (
      output bit_valid,
      output bit_data,
      input  bit_ready,
      input  phase,
      input  phase_valid,
      input  symbol_start
   );

   modport slave (
      input  bit_valid,
      input  bit_data,
      output bit_ready,
      output phase,
      output phase_valid,
      output symbol_start
   );
endinterface

// File: rtl/bpsk_phase_sequencer.sv
// ---------------------------------------------------------------------------
// bpsk_phase_sequencer
// Turns a stream of data bits into sine-table phase indices for a BPSK
// carrier. A free-running carrier accumulator advances PHASE_STEP per sample
// (modulo 2*SINE_RESOLUTION); each symbol adds 0 or SINE_RESOLUTION steps.
// One bit is consumed every SAMPLES_PER_SYMBOL samples via valid/ready.
//
// Ports:
//   clk       : sample clock
//   reset_n   : asynchronous active-low reset
//   enable    : allows new bursts and continuation past a symbol boundary
//   bus       : slave modport of bpsk_phase_sequencer_if (bit handshake in,
//               phase / phase_valid / symbol_start out)
//   underrun  : one-cycle pulse, burst ended because no bit was available
//   busy      : sequencer is emitting a burst
//
// Optional build macro: BPSK_DIFF_EN enables differential (DBPSK) encoding;
// each burst references 0 deg.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no burst, carrier parked at 0, waiting for enable & bit_valid
// SEND  | presenting sample sample_cnt of the current symbol
// ---------------------------------------------------------------------------
module bpsk_phase_sequencer #(
   parameter int DATA_WIDTH         = 8,
   parameter int SINE_RESOLUTION    = 128,
   parameter int PHASE_STEP         = 1,
   parameter int SAMPLES_PER_SYMBOL = 256
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   enable,
   bpsk_phase_sequencer_if.slave  bus,
   output logic                   underrun,
   output logic                   busy
);

   // One extra bit so 2*SINE_RESOLUTION == 2**DATA_WIDTH still fits.
   localparam int                PW       = DATA_WIDTH + 1;
   localparam int                CNT_W    = $clog2(SAMPLES_PER_SYMBOL);
   localparam logic [PW-1:0]     PERIOD   = PW'(2 * SINE_RESOLUTION);
   localparam logic [PW-1:0]     HALF     = PW'(SINE_RESOLUTION);
   localparam logic [PW-1:0]     STEP     = PW'(PHASE_STEP);
   localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(SAMPLES_PER_SYMBOL - 1);

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_t;

   state_t                 state;
   logic [DATA_WIDTH-1:0]  carrier;
   logic [CNT_W-1:0]       sample_cnt;
   logic                   cur_bit;
   logic [DATA_WIDTH-1:0]  phase_q;
   logic                   phase_valid_q;
   logic                   symbol_start_q;
   logic                   underrun_q;

   logic                   last_sample;
   logic                   ready;
   logic                   accept;
   logic                   new_bit;
   logic [DATA_WIDTH-1:0]  carrier_next;

   // Both operands are below PERIOD, so a single conditional subtract is an
   // exact modulo.
   function automatic logic [DATA_WIDTH-1:0] wrap_add(
      input logic [DATA_WIDTH-1:0] a,
      input logic [PW-1:0]         b
   );
      logic [PW-1:0] sum;
      sum = {1'b0, a} + b;
      if (sum >= PERIOD) begin
         sum = sum - PERIOD;
      end
      return sum[DATA_WIDTH-1:0];
   endfunction

   function automatic logic [PW-1:0] offset_of(input logic b);
      return b ? HALF : '0;
   endfunction

   assign last_sample  = (state == SEND) && (sample_cnt == LAST_CNT);
   assign ready        = enable && ((state == IDLE) || last_sample);
   assign accept       = ready && bus.bit_valid;
   assign carrier_next = wrap_add(carrier, STEP);

`ifdef BPSK_DIFF_EN
   logic prev_bit;

   assign new_bit = prev_bit ^ bus.bit_data;

   // prev_bit is 0 throughout IDLE, so the first bit of a burst is
   // referenced to 0 deg.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         prev_bit <= 1'b0;
      end else if (accept) begin
         prev_bit <= new_bit;
      end else if (last_sample) begin
         prev_bit <= 1'b0;
      end
   end
`else
   assign new_bit = bus.bit_data;
`endif

   // Outputs are registered from the next-state values, so phase always
   // belongs to the sample described by carrier/cur_bit/sample_cnt.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state          <= IDLE;
         carrier        <= '0;
         sample_cnt     <= '0;
         cur_bit        <= 1'b0;
         phase_q        <= '0;
         phase_valid_q  <= 1'b0;
         symbol_start_q <= 1'b0;
         underrun_q     <= 1'b0;
      end else begin
         underrun_q <= 1'b0;
         case (state)
            IDLE: begin
               carrier        <= '0;
               sample_cnt     <= '0;
               phase_q        <= '0;
               phase_valid_q  <= 1'b0;
               symbol_start_q <= 1'b0;
               if (accept) begin
                  state          <= SEND;
                  cur_bit        <= new_bit;
                  phase_q        <= wrap_add('0, offset_of(new_bit));
                  phase_valid_q  <= 1'b1;
                  symbol_start_q <= 1'b1;
               end
            end
            SEND: begin
               if (!last_sample) begin
                  carrier        <= carrier_next;
                  sample_cnt     <= sample_cnt + CNT_W'(1);
                  phase_q        <= wrap_add(carrier_next, offset_of(cur_bit));
                  symbol_start_q <= 1'b0;
               end else if (accept) begin
                  // Carrier keeps running across the symbol boundary.
                  carrier        <= carrier_next;
                  sample_cnt     <= '0;
                  cur_bit        <= new_bit;
                  phase_q        <= wrap_add(carrier_next, offset_of(new_bit));
                  symbol_start_q <= 1'b1;
               end else begin
                  // enable low here means a deliberate stop, not a starved source.
                  state          <= IDLE;
                  carrier        <= '0;
                  sample_cnt     <= '0;
                  cur_bit        <= 1'b0;
                  phase_q        <= '0;
                  phase_valid_q  <= 1'b0;
                  symbol_start_q <= 1'b0;
                  underrun_q     <= enable;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.bit_ready    = ready;
   assign bus.phase        = phase_q;
   assign bus.phase_valid  = phase_valid_q;
   assign bus.symbol_start = symbol_start_q;
   assign underrun         = underrun_q;
   assign busy             = (state == SEND);

endmodule

// File: tb/tb_bpsk_phase_sequencer.sv
module tb_bpsk_phase_sequencer;
   localparam int DW     = 8;
   localparam int SR     = 4;
   localparam int PERIOD = 2 * SR;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n, enable, bit_valid, bit_data, sel;
   logic en_a, en_b;
   logic underrun_a, busy_a, underrun_b, busy_b;
   int   checks = 0;
   int   errors = 0;
   bit   q[$];

   bpsk_phase_sequencer_if #(.DATA_WIDTH(DW)) if_a ();
   bpsk_phase_sequencer_if #(.DATA_WIDTH(DW)) if_b ();

   assign en_a = enable & ~sel;
   assign en_b = enable & sel;
   assign if_a.bit_valid = bit_valid;
   assign if_a.bit_data  = bit_data;
   assign if_b.bit_valid = bit_valid;
   assign if_b.bit_data  = bit_data;

   bpsk_phase_sequencer #(
      .DATA_WIDTH(DW), .SINE_RESOLUTION(SR), .PHASE_STEP(1), .SAMPLES_PER_SYMBOL(3)
   ) dut_a (
      .clk(clk), .reset_n(reset_n), .enable(en_a), .bus(if_a.slave),
      .underrun(underrun_a), .busy(busy_a)
   );

   bpsk_phase_sequencer #(
      .DATA_WIDTH(DW), .SINE_RESOLUTION(SR), .PHASE_STEP(3), .SAMPLES_PER_SYMBOL(4)
   ) dut_b (
      .clk(clk), .reset_n(reset_n), .enable(en_b), .bus(if_b.slave),
      .underrun(underrun_b), .busy(busy_b)
   );

   logic [DW-1:0] o_phase;
   logic          o_valid, o_sstart, o_ready, o_underrun, o_busy;
   assign o_phase    = sel ? if_b.phase        : if_a.phase;
   assign o_valid    = sel ? if_b.phase_valid  : if_a.phase_valid;
   assign o_sstart   = sel ? if_b.symbol_start : if_a.symbol_start;
   assign o_ready    = sel ? if_b.bit_ready    : if_a.bit_ready;
   assign o_underrun = sel ? underrun_b        : underrun_a;
   assign o_busy     = sel ? busy_b            : busy_a;

   // Sample j of a burst: carrier has advanced j steps from 0, plus 180 deg for a 1.
   function automatic logic [DW-1:0] exp_phase(input int j, input int step, input bit b);
      return DW'((j * step + (b ? SR : 0)) % PERIOD);
   endfunction

   task automatic test_reset();
      reset_n = 1'b0; enable = 1'b0; bit_valid = 1'b1; bit_data = 1'b1; sel = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         sel = i[0];
         @(negedge clk);
         checks++;
         if (o_phase !== '0 || o_valid !== 1'b0 || o_ready !== 1'b0 ||
             o_busy !== 1'b0 || o_underrun !== 1'b0 || o_sstart !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle sel=%0d got phase=%0d valid=%b ready=%b busy=%b underrun=%b sstart=%b want all 0",
                     sel, o_phase, o_valid, o_ready, o_busy, o_underrun, o_sstart);
         end
         @(posedge clk); #1;
      end
      sel = 1'b0;
   endtask

   // One burst on the selected instance; drop_at >= 0 lowers enable at that
   // sample index, clean lowers enable at the final sample.
   task automatic test_burst(input bit s, input bit bits[$], input int drop_at, input bit clean);
      int  step, sps, n_sym, k, r;
      bit  stop_clean, acc, exp_ready;
      bit  eb[$];
      logic [DW-1:0] ep;
      step = s ? 3 : 1;
      sps  = s ? 4 : 3;
      acc  = 1'b0;
      foreach (bits[i]) begin
`ifdef BPSK_DIFF_EN
         acc = acc ^ bits[i];
         eb.push_back(acc);
`else
         eb.push_back(bits[i]);
`endif
      end
      if (drop_at >= 0) begin
         n_sym = drop_at / sps + 1;
         stop_clean = 1'b1;
      end else begin
         n_sym = bits.size();
         stop_clean = clean;
      end
      sel = s; enable = 1'b1; bit_valid = 1'b1; bit_data = bits[0];
      @(negedge clk);
      checks++;
      if (o_ready !== 1'b1 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL idle_ready got ready=%b busy=%b want ready=1 busy=0", o_ready, o_busy);
      end
      @(posedge clk); #1;
      for (int j = 0; j < n_sym * sps; j++) begin
         k = j / sps;
         r = j % sps;
         if (drop_at >= 0 && j >= drop_at) enable = 1'b0;
         if (r == sps - 1) begin
            if (k + 1 < bits.size()) begin
               bit_valid = 1'b1; bit_data = bits[k + 1];
            end else begin
               bit_valid = 1'b0; bit_data = 1'($urandom);
               if (clean) enable = 1'b0;
            end
         end else begin
            bit_valid = 1'($urandom); bit_data = 1'($urandom);
         end
         exp_ready = (r == sps - 1) && enable;
         ep = exp_phase(j, step, eb[k]);
         @(negedge clk);
         checks++;
         if (o_phase !== ep) begin
            errors++;
            $display("FAIL phase sel=%0d j=%0d got %0d want %0d", s, j, o_phase, ep);
         end
         checks++;
         if (o_valid !== 1'b1 || o_busy !== 1'b1 || o_underrun !== 1'b0) begin
            errors++;
            $display("FAIL live_flags j=%0d got valid=%b busy=%b underrun=%b want 1 1 0",
                     j, o_valid, o_busy, o_underrun);
         end
         checks++;
         if (o_sstart !== (r == 0)) begin
            errors++;
            $display("FAIL symbol_start j=%0d got %b want %b", j, o_sstart, (r == 0));
         end
         checks++;
         if (o_ready !== exp_ready) begin
            errors++;
            $display("FAIL bit_ready j=%0d got %b want %b", j, o_ready, exp_ready);
         end
         @(posedge clk); #1;
      end
      bit_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (o_valid !== 1'b0 || o_phase !== '0 || o_busy !== 1'b0 || o_underrun !== !stop_clean) begin
         errors++;
         $display("FAIL burst_end got valid=%b phase=%0d busy=%b underrun=%b want 0 0 0 %b",
                  o_valid, o_phase, o_busy, o_underrun, !stop_clean);
      end
      @(posedge clk); #1;
      enable = 1'b0;
      @(negedge clk);
      checks++;
      if (o_underrun !== 1'b0 || o_valid !== 1'b0) begin
         errors++;
         $display("FAIL underrun_pulse got underrun=%b valid=%b want 0 0", o_underrun, o_valid);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      sel = 1'b0; enable = 1'b1; bit_valid = 1'b1; bit_data = 1'b1;
      @(posedge clk); #1;
      bit_valid = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      checks++;
      if (o_phase !== DW'(SR + 1) || o_busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset got phase=%0d busy=%b want %0d 1", o_phase, o_busy, SR + 1);
      end
      #1 reset_n = 1'b0;
      #1;
      checks++;
      if (o_phase !== '0 || o_valid !== 1'b0 || o_sstart !== 1'b0 ||
          o_busy !== 1'b0 || o_underrun !== 1'b0) begin
         errors++;
         $display("FAIL reset_abort got phase=%0d valid=%b sstart=%b busy=%b underrun=%b want all 0",
                  o_phase, o_valid, o_sstart, o_busy, o_underrun);
      end
      enable = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      q = {1'b0};             test_burst(1'b0, q, -1, 1'b0);
      q = {1'b1, 1'b0, 1'b1}; test_burst(1'b0, q, -1, 1'b0);
      q = {1'b0};             test_burst(1'b1, q, -1, 1'b0);
      q = {1'b1, 1'b0};       test_burst(1'b0, q, 0, 1'b0);
      q = {1'b1, 1'b1, 1'b0}; test_burst(1'b0, q, -1, 1'b1);
      q = {1'b1, 1'b1, 1'b0}; test_burst(1'b1, q, 5, 1'b0);
      test_reset_mid();
      q = {1'b1};             test_burst(1'b0, q, -1, 1'b0);
      for (int it = 0; it < 8; it++) begin
         int n;
         n = $urandom_range(1, 5);
         q.delete();
         for (int i = 0; i < n; i++) q.push_back(1'($urandom));
         test_burst(1'($urandom), q, -1, 1'($urandom));
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
